de0_vga: RTL and testbench
==========================

// Module: de0_vga
// PURPOSE
//  VGA raster timing generator and RGB output stage for the DE0 board.
//  Default mode is 1280x1024@60 (108 MHz pixel clock, 4-bit-per-channel DAC).
//  Publishes the current raster position and visible flags to the frame
//  renderer, registers the renderer's 12-bit colour, and drives the VGA
//  pins with sync aligned to the pixel data.
// PARAMETERS
//  H_VISIBLE 1280  active pixels per line
//  H_FP      48    horizontal front porch (pixels)
//  H_SYNC    112   horizontal sync width (pixels)
//  H_BP      248   horizontal back porch (pixels); line total 1688
//  V_VISIBLE 1024  active lines per frame
//  V_FP      1     vertical front porch (lines)
//  V_SYNC    3     vertical sync width (lines)
//  V_BP      38    vertical back porch (lines); frame total 1066
//  HS_POL    1     HS active level (1 = positive)
//  VS_POL    1     VS active level (1 = positive)
// PORTS
//  clk_50      in   1   sole clock (name kept from board; drive at pixel rate, 108 MHz for default mode)
//  rst         in   1   reset: synchronous, active-high
//  pixel_color in   12  {R[11:8],G[7:4],B[3:0]} for position presented 1 cycle earlier
//  VGA_BUS_R   out  4   red DAC
//  VGA_BUS_G   out  4   green DAC
//  VGA_BUS_B   out  4   blue DAC
//  VGA_HS      out  1   horizontal sync
//  VGA_VS      out  1   vertical sync
//  X_pix       out  11  horizontal counter, 0..H_total-1
//  Y_pix       out  11  vertical counter, 0..V_total-1
//  H_visible   out  1   1 when X_pix < H_VISIBLE
//  V_visible   out  1   1 when Y_pix < V_VISIBLE
//  pixel_clk   out  1   copy of clk_50; all consumers run on it
//  pixel_cnt   out  10  X_pix[9:0]
// BEHAVIOUR
//  - Counters: h_cnt increments every clock; at H_total-1 it wraps to 0 and
//    v_cnt increments; v_cnt wraps to 0 after V_total-1 (same edge as h wrap).
//  - X_pix, Y_pix, H_visible, V_visible, pixel_cnt are registered from the
//    counters (all change on the same edge; stage 0).
//  - Sync: HS active while H_VISIBLE+H_FP <= h_cnt < H_VISIBLE+H_FP+H_SYNC;
//    VS active while V_VISIBLE+V_FP <= v_cnt < V_VISIBLE+V_FP+V_SYNC.
//    Sync and visible-AND are delayed two stages to match colour path.
//  - Colour: consumer registers pixel_color one cycle after X_pix/Y_pix;
//    this block registers it again: RGB = visible_d2 ? pixel_color : 0.
//    Total latency position->pins = 2 clocks; HS/VS/RGB always aligned.
//  - Blanking: RGB forced to 0 outside H_VISIBLE x V_VISIBLE, regardless of
//    pixel_color.
//  - Reset: h_cnt=v_cnt=0, X_pix=Y_pix=0, pixel_cnt=0, H_visible=V_visible=0
//    while rst high, RGB=0, HS=~HS_POL, VS=~VS_POL, pipeline cleared. First
//    clock after rst low presents X_pix=0,Y_pix=0, visible=1.
//  - Reset mid-frame restarts at (0,0) on the next edge; no partial sync
//    pulse may extend past reset.
//  - pixel_clk is a combinational copy of clk_50 (no divider, no gating).
// STRUCTURE
//  - Shared package: timing constants for supported modes (1280x1024@60,
//    640x480@60) and the 12-bit colour typedef {r,g,b} of 4 bits each.
//  - One natural sub-module: vga_axis_counter (counter + visible/sync
//    decode), instantiated once for H and once for V with V enabled by H wrap.
// TESTING
//  - Reset held 5 clk, released -> X_pix=0,Y_pix=0,HS=VS=0,RGB=0; next clk X_pix=1.
//  - Free run one line -> X_pix wraps 1687->0, Y_pix 0->1 on that edge; HS high
//    exactly 112 clk, first HS-high output 2 clk after X_pix=1328.
//  - Free run one frame -> VS high for 3 lines (3*1688 clk) starting Y_pix=1025
//    (+2 clk); frame period 1688*1066 = 1,799,408 clk.
//  - pixel_color=12'hF0A constant -> R=F,G=0,B=A on pins only for visible
//    positions; 0 during X_pix>=1280 or Y_pix>=1024 (checked at 2-clk offset).
//  - pixel_color = {X_pix[3:0],X_pix[3:0],X_pix[3:0]} registered externally ->
//    pin R equals X_pix[3:0] sampled 2 clk earlier for every visible pixel.
//  - Assert rst at X_pix=700,Y_pix=500 during HS-inactive -> next edge counters
//    0, HS/VS inactive, RGB=0; resumes normal timing from (0,0).

Source files
------------

// File: rtl/de0_vga_pkg.sv
// Shared raster timing for the supported DE0 VGA modes and the 12-bit colour type.
package de0_vga_pkg;

    localparam int CNT_W = 11;

    typedef enum logic [0:0] {
        MODE_SXGA = 1'b0,
        MODE_VGA  = 1'b1
    } mode_e;

    typedef struct packed {
        int   h_visible;
        int   h_fp;
        int   h_sync;
        int   h_bp;
        int   v_visible;
        int   v_fp;
        int   v_sync;
        int   v_bp;
        logic hs_pol;
        logic vs_pol;
    } timing_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    localparam rgb12_t RGB_BLACK = '{r: 4'h0, g: 4'h0, b: 4'h0};

    // 1280x1024@60 at 108 MHz, and 640x480@60 at 25.175 MHz
    localparam timing_t SXGA_TIMING = '{1280, 48, 112, 248, 1024, 1, 3, 38, 1'b1, 1'b1};
    localparam timing_t VGA_TIMING  = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};

    function automatic timing_t mode_timing(input mode_e mode);
        case (mode)
            MODE_SXGA: return SXGA_TIMING;
            MODE_VGA:  return VGA_TIMING;
            default:   return SXGA_TIMING;
        endcase
    endfunction

    localparam timing_t DEFAULT_TIMING = mode_timing(MODE_SXGA);

    function automatic logic sync_level(input logic active, input logic pol);
        if (active) begin
            return pol;
        end else begin
            return ~pol;
        end
    endfunction

endpackage

// File: rtl/de0_vga_axis_counter.sv
// One raster axis: wrapping position counter with registered position,
// visible and raw (active-high) sync decode.
module vga_axis_counter
    import de0_vga_pkg::*;
#(
    parameter int VISIBLE = 1280,
    parameter int FP      = 48,
    parameter int SYNC    = 112,
    parameter int BP      = 248
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic             wrap_o,
    output logic [CNT_W-1:0] pos_o,
    output logic             visible_o,
    output logic             sync_o
);

    localparam logic [CNT_W-1:0] LAST_C       = CNT_W'(VISIBLE + FP + SYNC + BP - 1);
    localparam logic [CNT_W-1:0] VIS_C        = CNT_W'(VISIBLE);
    localparam logic [CNT_W-1:0] SYNC_START_C = CNT_W'(VISIBLE + FP);
    localparam logic [CNT_W-1:0] SYNC_END_C   = CNT_W'(VISIBLE + FP + SYNC);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] pos_q;
    logic             visible_q;
    logic             visible_d;
    logic             sync_q;
    logic             sync_d;

    assign wrap_o = en_i && (cnt_q == LAST_C);

    // Next count and stage-0 decode of the current count.
    always_comb begin
        cnt_d     = cnt_q;
        visible_d = 1'b0;
        sync_d    = 1'b0;
        if (wrap_o) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        visible_d = (cnt_q < VIS_C);
        sync_d    = (cnt_q >= SYNC_START_C) && (cnt_q < SYNC_END_C);
    end

    // Counter and stage-0 registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= {CNT_W{1'b0}};
            pos_q     <= {CNT_W{1'b0}};
            visible_q <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pos_q     <= cnt_q;
            visible_q <= visible_d;
            sync_q    <= sync_d;
        end
    end

    assign pos_o     = pos_q;
    assign visible_o = visible_q;
    assign sync_o    = sync_q;

endmodule

// File: rtl/de0_vga.sv
// VGA raster generator and RGB output stage: publishes the raster position,
// re-registers the renderer colour and keeps HS/VS aligned with it at the pins.
module de0_vga
    import de0_vga_pkg::*;
#(
    parameter int   H_VISIBLE = DEFAULT_TIMING.h_visible,
    parameter int   H_FP      = DEFAULT_TIMING.h_fp,
    parameter int   H_SYNC    = DEFAULT_TIMING.h_sync,
    parameter int   H_BP      = DEFAULT_TIMING.h_bp,
    parameter int   V_VISIBLE = DEFAULT_TIMING.v_visible,
    parameter int   V_FP      = DEFAULT_TIMING.v_fp,
    parameter int   V_SYNC    = DEFAULT_TIMING.v_sync,
    parameter int   V_BP      = DEFAULT_TIMING.v_bp,
    parameter logic HS_POL    = DEFAULT_TIMING.hs_pol,
    parameter logic VS_POL    = DEFAULT_TIMING.vs_pol
) (
    input  logic        clk_50,
    input  logic        rst,
    input  logic [11:0] pixel_color,
    output logic [3:0]  VGA_BUS_R,
    output logic [3:0]  VGA_BUS_G,
    output logic [3:0]  VGA_BUS_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic [10:0] X_pix,
    output logic [10:0] Y_pix,
    output logic        H_visible,
    output logic        V_visible,
    output logic        pixel_clk,
    output logic [9:0]  pixel_cnt
);

    logic             h_wrap_s;
    logic             v_wrap_unused_s;
    logic [CNT_W-1:0] x_s;
    logic [CNT_W-1:0] y_s;
    logic             h_vis_s;
    logic             v_vis_s;
    logic             h_sync_s;
    logic             v_sync_s;

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FP      (H_FP),
        .SYNC    (H_SYNC),
        .BP      (H_BP)
    ) u_h_axis (
        .clk_i     (clk_50),
        .rst_i     (rst),
        .en_i      (1'b1),
        .wrap_o    (h_wrap_s),
        .pos_o     (x_s),
        .visible_o (h_vis_s),
        .sync_o    (h_sync_s)
    );

    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FP      (V_FP),
        .SYNC    (V_SYNC),
        .BP      (V_BP)
    ) u_v_axis (
        .clk_i     (clk_50),
        .rst_i     (rst),
        .en_i      (h_wrap_s),
        .wrap_o    (v_wrap_unused_s),
        .pos_o     (y_s),
        .visible_o (v_vis_s),
        .sync_o    (v_sync_s)
    );

    // Stage 1 waits for the renderer's registered colour; stage 2 drives the pins.
    logic   vis_pipe_q;
    logic   hs_pipe_q;
    logic   vs_pipe_q;
    logic   hs_q;
    logic   hs_d;
    logic   vs_q;
    logic   vs_d;
    rgb12_t rgb_q;
    rgb12_t rgb_d;

    // Pin values: blank colour outside the visible area, apply sync polarity.
    always_comb begin
        rgb_d = RGB_BLACK;
        if (vis_pipe_q) begin
            rgb_d = rgb12_t'(pixel_color);
        end else begin
            rgb_d = RGB_BLACK;
        end
        hs_d = sync_level(hs_pipe_q, HS_POL);
        vs_d = sync_level(vs_pipe_q, VS_POL);
    end

    // Sync/visible delay stage and output registers.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            vis_pipe_q <= 1'b0;
            hs_pipe_q  <= 1'b0;
            vs_pipe_q  <= 1'b0;
            hs_q       <= ~HS_POL;
            vs_q       <= ~VS_POL;
            rgb_q      <= RGB_BLACK;
        end else begin
            vis_pipe_q <= h_vis_s && v_vis_s;
            hs_pipe_q  <= h_sync_s;
            vs_pipe_q  <= v_sync_s;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            rgb_q      <= rgb_d;
        end
    end

    assign VGA_BUS_R = rgb_q.r;
    assign VGA_BUS_G = rgb_q.g;
    assign VGA_BUS_B = rgb_q.b;
    assign VGA_HS    = hs_q;
    assign VGA_VS    = vs_q;
    assign X_pix     = x_s;
    assign Y_pix     = y_s;
    assign H_visible = h_vis_s;
    assign V_visible = v_vis_s;
    assign pixel_cnt = x_s[9:0];
    assign pixel_clk = clk_50;

endmodule

// File: tb/tb_de0_vga.sv
// Scoreboard bench for de0_vga: full horizontal timing, shortened frame height
// so whole frames, wraps and mid-frame resets fit a short run.
module tb_de0_vga;

    localparam int HV    = 1280;
    localparam int HF    = 48;
    localparam int HSW   = 112;
    localparam int HB    = 248;
    localparam int HT    = HV + HF + HSW + HB;
    localparam int VV    = 8;
    localparam int VF    = 1;
    localparam int VSW   = 3;
    localparam int VB    = 2;
    localparam int VT    = VV + VF + VSW + VB;
    localparam int FRAME = HT * VT;

    logic        clk_50 = 1'b0;
    logic        rst;
    logic [11:0] pixel_color;
    logic [3:0]  VGA_BUS_R;
    logic [3:0]  VGA_BUS_G;
    logic [3:0]  VGA_BUS_B;
    logic        VGA_HS;
    logic        VGA_VS;
    logic [10:0] X_pix;
    logic [10:0] Y_pix;
    logic        H_visible;
    logic        V_visible;
    logic        pixel_clk;
    logic [9:0]  pixel_cnt;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [13:0] exp_q[$];

    de0_vga #(
        .H_VISIBLE (HV),
        .H_FP      (HF),
        .H_SYNC    (HSW),
        .H_BP      (HB),
        .V_VISIBLE (VV),
        .V_FP      (VF),
        .V_SYNC    (VSW),
        .V_BP      (VB),
        .HS_POL    (1'b1),
        .VS_POL    (1'b1)
    ) dut (
        .clk_50      (clk_50),
        .rst         (rst),
        .pixel_color (pixel_color),
        .VGA_BUS_R   (VGA_BUS_R),
        .VGA_BUS_G   (VGA_BUS_G),
        .VGA_BUS_B   (VGA_BUS_B),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .X_pix       (X_pix),
        .Y_pix       (Y_pix),
        .H_visible   (H_visible),
        .V_visible   (V_visible),
        .pixel_clk   (pixel_clk),
        .pixel_cnt   (pixel_cnt)
    );

    always #5 clk_50 = ~clk_50;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [13:0] pins_for(input int h, input int v, input logic [11:0] c);
        logic vis;
        logic hs;
        logic vs;
        vis = (h < HV) && (v < VV);
        hs  = (h >= HV + HF) && (h < HV + HF + HSW);
        vs  = (v >= VV + VF) && (v < VV + VF + VSW);
        return {(vis ? c : 12'h000), hs, vs};
    endfunction

    function automatic logic [11:0] colour_for(input int h, input int v);
        logic [3:0] n;
        n = h[3:0];
        case (v % 3)
            0:       return 12'hF0A;
            1:       return {n, n, n};
            default: return 12'($urandom_range(0, 4095));
        endcase
    endfunction

    task automatic apply_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk_50);
            #1;
            check("rst_state", 64'({X_pix, Y_pix, H_visible, V_visible, pixel_cnt,
                                    VGA_BUS_R, VGA_BUS_G, VGA_BUS_B, VGA_HS, VGA_VS}), 64'h0);
        end
        rst = 1'b0;
    endtask

    task automatic run_phase(input int n, input bit measure);
        logic [11:0] c_prev;
        int          h;
        int          v;
        int          hs_cnt;
        int          vs_cnt;
        int          hs_first;
        int          vs_first;
        c_prev   = 12'h000;
        hs_cnt   = 0;
        vs_cnt   = 0;
        hs_first = -1;
        vs_first = -1;
        exp_q.delete();
        exp_q.push_back(14'h0000);
        exp_q.push_back(14'h0000);
        for (int t = 0; t < n; t++) begin
            @(posedge clk_50);
            #1;
            h = t % HT;
            v = (t / HT) % VT;
            check("pos", 64'({Y_pix, X_pix, V_visible, H_visible, pixel_cnt}),
                  64'({11'(v), 11'(h), (v < VV), (h < HV), 10'(h)}));
            if (exp_q.size() == 0) begin
                check("sb_empty", 64'(0), 64'(1));
            end else begin
                check("pins", 64'({VGA_BUS_R, VGA_BUS_G, VGA_BUS_B, VGA_HS, VGA_VS}),
                      64'(exp_q.pop_front()));
            end
            if (measure) begin
                if (VGA_HS && (t >= 2) && (t < 2 + HT)) hs_cnt++;
                if (VGA_VS && (t >= 2) && (t < 2 + FRAME)) vs_cnt++;
                if (VGA_HS && (hs_first < 0)) hs_first = t;
                if (VGA_VS && (vs_first < 0)) vs_first = t;
            end
            if (t >= 1) begin
                pixel_color = c_prev;
                exp_q.push_back(pins_for((t - 1) % HT, ((t - 1) / HT) % VT, c_prev));
            end
            c_prev = colour_for(h, v);
        end
        if (measure) begin
            check("hs_width", 64'(hs_cnt), 64'(HSW));
            check("hs_first", 64'(hs_first), 64'(HV + HF + 2));
            check("vs_width", 64'(vs_cnt), 64'(VSW * HT));
            check("vs_first", 64'(vs_first), 64'((VV + VF) * HT + 2));
        end
    endtask

    initial begin
        rst         = 1'b1;
        pixel_color = 12'h000;
        @(posedge clk_50);
        #1;
        check("pclk_high", 64'(pixel_clk), 64'(1));
        @(negedge clk_50);
        #1;
        check("pclk_low", 64'(pixel_clk), 64'(0));
        apply_reset(5);
        // Full frame plus two lines, stopping at (700,2) with HS inactive.
        run_phase(FRAME + 2 * HT + 701, 1'b1);
        apply_reset(2);
        // Stop at (1350,10), inside both HS and VS pulses.
        run_phase(10 * HT + 1351, 1'b0);
        apply_reset(1);
        run_phase(2 * HT, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
